pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised elastic pipeline-stage buffer: the next-generation replacement for the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque packed payload of DATA_W bits through a DEPTH-entry circular queue. It adds a valid/ready handshake, a synchronous flush for branch/jump squash, and honours the global `rdy` pause. Each stage instantiates one copy, with the packed field bundle (opcode, funct3/7, operands, wd, wreg, …) as payload.

## Interface
- DATA_W, default 64: payload width in bits; legal range 1..256.
- DEPTH, default 2: number of entries; power of two, 2..16.
- NOP_VALUE, default {DATA_W{1'b0}}: value driven on out_data when the buffer is empty (the stage's bubble encoding).
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- rdy  input  1  global run enable; low = pause; no state change, no handshakes.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream has a payload.
- in_data  input  DATA_W  upstream payload.
- in_ready  output  1  buffer accepts in_data this cycle.
- out_valid  output  1  out_data holds a valid entry.
- out_data  output  DATA_W  head entry, or NOP_VALUE when empty.
- out_ready  input  1  downstream consumes head this cycle.
- count  output  $clog2(DEPTH+1)  number of held entries.

## Operation
- State:
  - storage array mem[DEPTH] of DATA_W bits.
  - rd_ptr and wr_ptr, log2(DEPTH) bits each, wrapping modulo DEPTH.
  - cnt, 0..DEPTH.
- Derived signals: empty = (cnt==0); full = (cnt==DEPTH).
- Combinational outputs:
  - in_ready = !rst && rdy && !flush && !full.
  - out_valid = !rst && rdy && !flush && !empty.
  - out_data = empty ? NOP_VALUE : mem[rd_ptr]. Valid regardless of rdy, for debug visibility.
  - count = cnt.
- in_ready does not depend on out_ready. There is no combinational path from out_ready to in_ready.
- Handshake events:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
- Per-cycle priority at posedge:
  1. rst: rd_ptr = wr_ptr = cnt = 0. mem contents are don't-care.
  2. else if !rdy: hold all state. in_ready and out_valid are already 0.
  3. else if flush: rd_ptr = wr_ptr = cnt = 0. Any in_valid that cycle is dropped.
  4. else:
     - push writes mem[wr_ptr] and advances wr_ptr.
     - pop advances rd_ptr.
     - cnt += push − pop.
- Simultaneous push and pop: legal whenever !full. cnt is unchanged and the pointers both advance.
- Pop when empty, or push when full: impossible by construction.
- Producer protocol: once in_valid is raised, the producer holds in_valid and in_data stable until push. The buffer does not check this; the bench asserts it.
- No payload interpretation. The NOP_VALUE bubble is purely an output default and is never written into mem.

## Timing
- Latency:
  - A push into an empty buffer gives out_valid=1 with that data on the next cycle.
  - Minimum in-to-out latency is 1 cycle. There is no same-cycle bypass.
- Throughput: 1 entry/cycle sustained for DEPTH≥2 with out_ready held high.
- Backpressure:
  - With out_ready=0, DEPTH consecutive pushes fill the buffer.
  - in_ready drops in the cycle after the filling push.
  - in_ready recovers in the cycle after the first pop.
- Reset values (during rst and the first cycle after its release):
  - out_valid=0, in_ready=0 during rst.
  - out_data=NOP_VALUE, count=0.
  - in_ready=1 in the first cycle after release if rdy=1 and flush=0.
- Reset mid-operation: all entries are discarded at the next posedge. Nothing held is ever presented after reset.
- Flush:
  - One-cycle flush empties the buffer.
  - out_valid=0 during the flush cycle and the following cycle, unless a new push occurs in the following cycle. In that case out_valid=1 one cycle later.
- rdy low mid-stream: pointers, cnt and mem freeze. Resuming continues with the exact same head entry and order.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble. Order is strictly FIFO across the wrap.

## Test plan
- Reset and idle: hold rst 3 cycles, then release with rdy=1 -> during rst in_ready=0, out_valid=0, count=0, out_data=NOP_VALUE; first post-reset cycle in_ready=1.
- Streaming at DEPTH=4, DATA_W=32: push 0x1..0x10 on consecutive cycles with out_ready=1 -> out_data 0x1..0x10 in order, each one cycle after its push, no gaps; count never exceeds 1.
- Backpressure and wrap at DEPTH=4: push 0xA0..0xA3 with out_ready=0 -> count=4, in_ready=0. Pop one -> in_ready=1 next cycle. Push 0xA4 -> output order 0xA1, 0xA2, 0xA3, 0xA4.
- Flush with simultaneous traffic: buffer holds 3 entries; assert flush with in_valid=1 and out_ready=1 -> no pop that cycle, count=0 next cycle, and the incoming payload never appears on out_data.
- Pause: buffer holds 0x55, 0x66; drop rdy for 5 cycles while in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0, count stays 2. After resume, 0x55 then 0x66 pop in order.
- Reset mid-stream: buffer full at DEPTH=2; pulse rst for 1 cycle -> count=0 and out_data=NOP_VALUE at the next cycle, and no pre-reset entry is ever presented afterwards.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic inter-stage buffer carrying an opaque payload
// through a DEPTH-entry circular queue with valid/ready handshake,
// synchronous squash (flush) and global pause (rdy).
module pipe_stage_buf #(
  parameter int unsigned        DATA_W    = 64,
  parameter int unsigned        DEPTH     = 2,
  parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
  localparam int unsigned       PTR_W     = $clog2(DEPTH),
  localparam int unsigned       CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_cnt;

  logic w_empty;
  logic w_full;
  logic w_live;
  logic w_push;
  logic w_pop;

  // Handshake qualification; in_ready deliberately ignores out_ready so
  // there is no combinational path from downstream back to upstream.
  always_comb begin
    w_empty   = (r_cnt == '0);
    w_full    = (r_cnt == CNT_W'(DEPTH));
    w_live    = !rst && rdy && !flush;
    in_ready  = w_live && !w_full;
    out_valid = w_live && !w_empty;
    w_push    = in_valid && in_ready;
    w_pop     = out_valid && out_ready;
    out_data  = w_empty ? NOP_VALUE : r_mem[r_rd_ptr];
    count     = r_cnt;
  end

  // Pointer and occupancy update: reset, then pause, then flush, then traffic.
  // Pointers are PTR_W bits and DEPTH is a power of two, so they wrap freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + CNT_W'(1);
          2'b01:   r_cnt <= r_cnt - CNT_W'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  // Payload storage; w_push already excludes reset, pause and flush.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed self-checking bench for pipe_stage_buf.
// Instance A: DATA_W=32, DEPTH=4. Instance B: DATA_W=16, DEPTH=2.
module tb_pipe_stage_buf;

  localparam logic [31:0] NOP_A = 32'hDEAD_BEEF;
  localparam logic [15:0] NOP_B = 16'h0BAD;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [2:0]  count;

  logic        rst_b, in_valid_b, out_ready_b;
  logic [15:0] in_data_b;
  logic        in_ready_b, out_valid_b;
  logic [15:0] out_data_b;
  logic [1:0]  count_b;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(32), .DEPTH(4), .NOP_VALUE(NOP_A)) u_dut_a (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
  );

  pipe_stage_buf #(.DATA_W(16), .DEPTH(2), .NOP_VALUE(NOP_B)) u_dut_b (
    .clk(clk), .rst(rst_b), .rdy(1'b1), .flush(1'b0),
    .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready_b),
    .count(count_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_a(input string tag, input logic ir, input logic ov,
                       input logic [31:0] od, input logic [2:0] c);
    check({tag, ".in_ready"},  64'(in_ready),  64'(ir));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
    check({tag, ".out_data"},  64'(out_data),  64'(od));
    check({tag, ".count"},     64'(count),     64'(c));
  endtask

  task automatic chk_b(input string tag, input logic ir, input logic ov,
                       input logic [15:0] od, input logic [1:0] c);
    check({tag, ".in_ready"},  64'(in_ready_b),  64'(ir));
    check({tag, ".out_valid"}, 64'(out_valid_b), 64'(ov));
    check({tag, ".out_data"},  64'(out_data_b),  64'(od));
    check({tag, ".count"},     64'(count_b),     64'(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic r, input logic rd, input logic fl,
                         input logic iv, input logic [31:0] d, input logic ordy);
    rst = r; rdy = rd; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
  endtask

  task automatic drive_b(input logic r, input logic iv, input logic [15:0] d, input logic ordy);
    rst_b = r; in_valid_b = iv; in_data_b = d; out_ready_b = ordy;
    #1;
  endtask

  // Producer rule on instance A: a pending, unaccepted payload must be held
  // unchanged until accepted (flush and reset drop it legitimately).
  logic        p_pend = 1'b0;
  logic [31:0] p_data = '0;
  always @(posedge clk) begin
    if (p_pend) check("proto_hold", {31'd0, in_valid, in_data}, {31'd0, 1'b1, p_data});
    p_pend <= in_valid && !in_ready && !flush && !rst;
    p_data <= in_data;
  end

  initial begin
    // ---- reset and idle ----
    drive_a(1, 1, 0, 0, '0, 0);
    drive_b(1, 0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("reset", 0, 0, NOP_A, 0);
    end
    drive_a(0, 1, 0, 0, '0, 0);
    drive_b(0, 0, '0, 0);
    chk_a("post_reset", 1, 0, NOP_A, 0);

    // ---- streaming with out_ready high: 1-cycle latency, no gaps ----
    for (int i = 1; i <= 16; i++) begin
      drive_a(0, 1, 0, 1, 32'(i), 1);
      chk_a("stream", 1, i > 1, (i > 1) ? 32'(i - 1) : NOP_A, (i > 1) ? 3'd1 : 3'd0);
      tick();
    end
    drive_a(0, 1, 0, 0, '0, 1);
    chk_a("stream_last", 1, 1, 32'h10, 1);
    tick();
    drive_a(0, 1, 0, 0, '0, 0);
    chk_a("stream_empty", 1, 0, NOP_A, 0);

    // ---- backpressure and wrap ----
    for (int k = 0; k < 4; k++) begin
      drive_a(0, 1, 0, 1, 32'hA0 + 32'(k), 0);
      chk_a("fill", 1, k > 0, (k > 0) ? 32'hA0 : NOP_A, 3'(k));
      tick();
    end
    drive_a(0, 1, 0, 0, '0, 1);
    chk_a("full", 0, 1, 32'hA0, 4);
    tick();
    drive_a(0, 1, 0, 1, 32'hA4, 0);
    chk_a("after_pop", 1, 1, 32'hA1, 3);
    tick();
    drive_a(0, 1, 0, 0, '0, 1);
    chk_a("refull", 0, 1, 32'hA1, 4);
    for (int k = 1; k <= 4; k++) begin
      check("wrap_order", 64'(out_data), 64'(32'hA0 + 32'(k)));
      check("wrap_valid", 64'(out_valid), 64'd1);
      tick();
    end
    drive_a(0, 1, 0, 0, '0, 0);
    chk_a("wrap_empty", 1, 0, NOP_A, 0);

    // ---- flush with simultaneous traffic ----
    for (int k = 1; k <= 3; k++) begin
      drive_a(0, 1, 0, 1, 32'hB0 + 32'(k), 0);
      tick();
    end
    drive_a(0, 1, 1, 1, 32'hCC, 1);
    chk_a("flush_cyc", 0, 0, 32'hB1, 3);
    tick();
    drive_a(0, 1, 0, 1, 32'hDD, 0);
    chk_a("flush_after", 1, 0, NOP_A, 0);
    tick();
    drive_a(0, 1, 0, 0, '0, 1);
    chk_a("flush_repush", 1, 1, 32'hDD, 1);
    tick();
    drive_a(0, 1, 0, 0, '0, 0);
    chk_a("flush_empty", 1, 0, NOP_A, 0);

    // ---- pause ----
    drive_a(0, 1, 0, 1, 32'h55, 0);
    tick();
    drive_a(0, 1, 0, 1, 32'h66, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive_a(0, 0, 0, 1, 32'h77, 1);
      chk_a("pause", 0, 0, 32'h55, 2);
      tick();
    end
    drive_a(0, 1, 0, 1, 32'h77, 1);
    chk_a("resume0", 1, 1, 32'h55, 2);
    tick();
    drive_a(0, 1, 0, 0, '0, 1);
    chk_a("resume1", 1, 1, 32'h66, 2);
    tick();
    chk_a("resume2", 1, 1, 32'h77, 1);
    tick();
    drive_a(0, 1, 0, 0, '0, 0);
    chk_a("resume_empty", 1, 0, NOP_A, 0);

    // ---- reset mid-stream on the DEPTH=2 instance ----
    drive_b(0, 1, 16'h1111, 0);
    chk_b("b_push0", 1, 0, NOP_B, 0);
    tick();
    drive_b(0, 1, 16'h2222, 0);
    chk_b("b_push1", 1, 1, 16'h1111, 1);
    tick();
    drive_b(0, 0, '0, 0);
    chk_b("b_full", 0, 1, 16'h1111, 2);
    drive_b(1, 0, '0, 1);
    check("b_rst.in_ready", 64'(in_ready_b), 64'd0);
    check("b_rst.out_valid", 64'(out_valid_b), 64'd0);
    tick();
    drive_b(0, 0, '0, 1);
    chk_b("b_post_rst", 1, 0, NOP_B, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_b("b_no_stale", 1, 0, NOP_B, 0);
    end
    drive_b(0, 1, 16'h3333, 0);
    tick();
    drive_b(0, 0, '0, 1);
    chk_b("b_new", 1, 1, 16'h3333, 1);
    tick();
    chk_b("b_new_empty", 1, 0, NOP_B, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
